// File: rtl/config_if.sv
// config_if: serial configuration chain link (strobe clock plus 16-bit word).
interface config_if;
  logic        data_clk;
  logic [15:0] data_in;
  modport master (output data_clk, data_in);
  modport slave  (input  data_clk, data_in);
endinterface

// File: rtl/synapse_dendrite_if.sv
// synapse_dendrite_if: membrane voltage from the dendrite, injected current back to it.
interface synapse_dendrite_if;
  logic [15:0] vmem;
  logic [15:0] output_current;
  modport synapse  (input vmem, output output_current);
  modport dendrite (output vmem, input output_current);
endinterface

// File: rtl/synapse_cond.sv
// synapse_cond: conductance synapse with spike-driven increment, exponential decay and saturated current drive.
module synapse_cond #(
  parameter int CUR_SHIFT   = 16,
  parameter int DECAY_SHIFT = 16
) (
  input  logic               clk,
  input  logic               reset,
  config_if.slave            cfg_in,
  config_if.master           cfg_out,
  synapse_dendrite_if.synapse dendrite,
  input  logic               pre_spike,
  output logic               active
);
  logic [15:0] weight_q, tau_q, erev_q, dout_q;
  logic [15:0] g_q, g_d, cur_q, cur_d, decay_raw, decay;
  logic        active_q, active_d;
  logic [31:0] prod_d;
  logic [16:0] sum;
  logic signed [16:0] diff;
  logic signed [33:0] prod_i, cur;
  // Config words ripple weight -> tau -> E_rev -> next element; no reset by design.
  always_ff @(posedge cfg_in.data_clk) begin
    weight_q <= cfg_in.data_in;
    tau_q    <= weight_q;
    erev_q   <= tau_q;
    dout_q   <= erev_q;
  end
  assign cfg_out.data_clk = cfg_in.data_clk;
  assign cfg_out.data_in  = dout_q;
  always_comb begin
    prod_d    = {16'd0, g_q} * {16'd0, tau_q};
    decay_raw = 16'(prod_d >> DECAY_SHIFT);
    decay     = (g_q != '0 && tau_q != '0 && decay_raw == '0) ? 16'd1 : decay_raw;
    sum       = {1'b0, g_q} - {1'b0, decay} + (pre_spike ? {1'b0, weight_q} : 17'd0);
    g_d       = sum[16] ? 16'hFFFF : sum[15:0];
    diff      = $signed({erev_q[15], erev_q}) - $signed({dendrite.vmem[15], dendrite.vmem});
    prod_i    = diff * $signed({1'b0, g_q});
    cur       = prod_i >>> CUR_SHIFT;
    cur_d     = (cur > 34'sd32767) ? 16'h7FFF : (cur < -34'sd32768) ? 16'h8000 : cur[15:0];
    active_d  = g_q != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      g_q      <= '0;
      cur_q    <= '0;
      active_q <= 1'b0;
    end else begin
      g_q      <= g_d;
      cur_q    <= cur_d;
      active_q <= active_d;
    end
  end
  assign dendrite.output_current = cur_q;
  assign active                  = active_q;
endmodule

// File: tb/tb_synapse_cond.sv
// tb_synapse_cond: directed vector table plus hand sequences for decay, saturation, readback and reset.
module tb_synapse_cond;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pre_spike = 1'b0;
  logic active;
  int n_cmp = 0;
  int n_bad = 0;
  config_if cin ();
  config_if cout ();
  synapse_dendrite_if den ();
  synapse_cond dut (
    .clk(clk), .reset(reset), .cfg_in(cin), .cfg_out(cout),
    .dendrite(den), .pre_spike(pre_spike), .active(active)
  );
  always #10 clk = ~clk;
  typedef struct {
    logic [15:0] e, w, v;
    int          n;
    logic [15:0] g, cur;
    logic        act;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic [15:0] w);
    cin.data_in = w;
    #1 cin.data_clk = 1'b1;
    #1 cin.data_clk = 1'b0;
  endtask
  task automatic load(input logic [15:0] e, input logic [15:0] t, input logic [15:0] w);
    push(e);
    push(t);
    push(w);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic spikes(input int n);
    pre_spike = 1'b1;
    repeat (n) tick();
    pre_spike = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    cin.data_clk = 1'b0;
    cin.data_in  = '0;
    den.vmem     = '0;
    tv[0] = '{16'h1000, 16'h4000, 16'h0000, 1, 16'h4000, 16'h0400, 1'b1};
    tv[1] = '{16'h8000, 16'hC000, 16'h7FFF, 2, 16'hFFFF, 16'h8000, 1'b1};
    tv[2] = '{16'h7FFF, 16'hC000, 16'h8000, 2, 16'hFFFF, 16'h7FFF, 1'b1};
    tv[3] = '{16'h0000, 16'h4000, 16'h1000, 1, 16'h4000, 16'hFC00, 1'b1};
    tv[4] = '{16'h0010, 16'h0100, 16'h0000, 1, 16'h0100, 16'h0000, 1'b1};
    tv[5] = '{16'h0000, 16'h0001, 16'h0001, 1, 16'h0001, 16'hFFFF, 1'b1};
    tv[6] = '{16'h1000, 16'h4000, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0};
    tv[7] = '{16'h2000, 16'h8000, 16'hF000, 1, 16'h8000, 16'h1800, 1'b1};
    tick();
    chk("reset_cur", den.output_current, 16'h0000);
    chk("reset_active", active, 1'b0);
    chk("reset_g", dut.g_q, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      do_reset();
      load(tv[i].e, 16'h0000, tv[i].w);
      den.vmem = tv[i].v;
      spikes(tv[i].n);
      chk($sformatf("vec%0d_g", i), dut.g_q, tv[i].g);
      tick();
      chk($sformatf("vec%0d_cur", i), den.output_current, tv[i].cur);
      chk($sformatf("vec%0d_active", i), active, tv[i].act);
    end
    load(16'h1000, 16'h0000, 16'h4000);
    push(16'hAAAA);
    chk("readback_erev", cout.data_in, 16'h1000);
    push(16'hBBBB);
    chk("readback_tau", cout.data_in, 16'h0000);
    push(16'hCCCC);
    chk("readback_weight", cout.data_in, 16'h4000);
    do_reset();
    load(16'h1000, 16'h0000, 16'h4000);
    den.vmem = 16'h0000;
    spikes(1);
    chk("single_g", dut.g_q, 16'h4000);
    chk("single_cur_lat", den.output_current, 16'h0000);
    chk("single_active_lat", active, 1'b0);
    tick();
    chk("single_cur", den.output_current, 16'h0400);
    chk("single_active", active, 1'b1);
    repeat (3) tick();
    chk("single_hold_cur", den.output_current, 16'h0400);
    chk("single_hold_g", dut.g_q, 16'h4000);
    den.vmem = 16'h0800;
    chk("vmem_lat", den.output_current, 16'h0400);
    tick();
    chk("vmem_cur", den.output_current, 16'h0200);
    do_reset();
    den.vmem = 16'h0000;
    load(16'h0000, 16'h8000, 16'h4000);
    spikes(1);
    chk("decay_g0", dut.g_q, 16'h4000);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("decay_g%0d", k), dut.g_q, 32'h4000 >> k);
    end
    tick();
    chk("decay_g_zero", dut.g_q, 16'h0000);
    chk("decay_active_hold", active, 1'b1);
    tick();
    chk("decay_active_fall", active, 1'b0);
    do_reset();
    load(16'h0000, 16'h0000, 16'h0001);
    spikes(1);
    chk("min_decay_g1", dut.g_q, 16'h0001);
    load(16'h0000, 16'h0001, 16'h0001);
    tick();
    chk("min_decay_g0", dut.g_q, 16'h0000);
    do_reset();
    load(16'h0000, 16'h0000, 16'h0100);
    spikes(32);
    chk("simul_pre", dut.g_q, 16'h2000);
    load(16'h0000, 16'h8000, 16'h0100);
    spikes(1);
    chk("simul_g", dut.g_q, 16'h1100);
    do_reset();
    load(16'h0000, 16'h0000, 16'h1000);
    spikes(3);
    chk("rst_pre_g", dut.g_q, 16'h3000);
    load(16'h1000, 16'h0000, 16'h4000);
    tick();
    chk("rst_pre_cur", den.output_current, 16'h0300);
    reset = 1'b1;
    pre_spike = 1'b1;
    tick();
    reset = 1'b0;
    pre_spike = 1'b0;
    chk("rst_g", dut.g_q, 16'h0000);
    chk("rst_cur", den.output_current, 16'h0000);
    chk("rst_active", active, 1'b0);
    spikes(1);
    chk("rst_after_g", dut.g_q, 16'h4000);
    tick();
    chk("rst_after_cur", den.output_current, 16'h0400);
    chk("rst_after_active", active, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
